// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin arbitrated mux.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam logic [NUM_REQ-1:0] SEL_NONE = 4'b0000;
  localparam logic [NUM_REQ-1:0] SEL0     = 4'b0001;
  localparam logic [NUM_REQ-1:0] SEL1     = 4'b0010;
  localparam logic [NUM_REQ-1:0] SEL2     = 4'b0100;
  localparam logic [NUM_REQ-1:0] SEL3     = 4'b1000;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus of the arbitrated mux: requests, data in, grant/data out.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       sel;
  logic [WIDTH-1:0] y;
  logic             y_vld;

  // requesters drive req/data and observe the grant and muxed data
  modport master (
    output req, d0, d1, d2, d3,
    input  sel, y, y_vld
  );

  // the arbiter consumes req/data and produces grant and muxed data
  modport slave (
    input  req, d0, d1, d2, d3,
    output sel, y, y_vld
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first set req bit searching ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] win,
  output logic [1:0] win_idx,
  output logic       any
);

  logic [1:0] w_idx;

  // walk the four positions starting at ptr, keep the first hit
  always_comb begin
    win     = SEL_NONE;
    win_idx = 2'd0;
    any     = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ptr + 2'(k);
      if (!any && req[w_idx]) begin
        any     = 1'b1;
        win_idx = w_idx;
        win     = SEL0 << w_idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// 4-input mux with round-robin arbitration and a per-grant hold limit.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_t       r_state, w_state_nxt;
  logic [3:0]       r_sel, w_sel_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [3:0]       r_hold, w_hold_nxt;
  logic [WIDTH-1:0] r_y;
  logic             r_y_vld;

  logic [3:0] w_win;
  logic [1:0] w_win_idx;
  logic       w_any;
  logic       w_owner_req;
  logic       w_others_req;

  // ptr always sits just past the last winner, so the current owner is
  // searched last and any other requester wins a hand-over first
  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  assign w_owner_req  = |(bus.req & r_sel);
  assign w_others_req = |(bus.req & ~r_sel);

  // state, grant, pointer and hold counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= SEL_NONE;
      r_ptr   <= 2'd0;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // next grant decision; only the owner's req bit matters while it holds
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win_idx + 2'd1;
          w_hold_nxt  = 4'd0;
        end
      end
      GRANT: begin
        if (w_owner_req) begin
          if (r_hold < HOLD_LAST) begin
            w_hold_nxt = r_hold + 4'd1;
          end else if (w_others_req) begin
            w_sel_nxt  = w_win;
            w_ptr_nxt  = w_win_idx + 2'd1;
            w_hold_nxt = 4'd0;
          end else begin
            w_hold_nxt = 4'd0;
          end
        end else if (w_any) begin
          w_sel_nxt  = w_win;
          w_ptr_nxt  = w_win_idx + 2'd1;
          w_hold_nxt = 4'd0;
        end else begin
          w_state_nxt = IDLE;
          w_sel_nxt   = SEL_NONE;
          w_hold_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = SEL_NONE;
      end
    endcase
  end

  // registered data mux driven by the previous cycle's grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_y_vld <= 1'b0;
    end else begin
      r_y_vld <= |r_sel;
      case (r_sel)
        SEL0:    r_y <= bus.d0;
        SEL1:    r_y <= bus.d1;
        SEL2:    r_y <= bus.d2;
        SEL3:    r_y <= bus.d3;
        default: r_y <= r_y;
      endcase
    end
  end

  assign bus.sel   = r_sel;
  assign bus.y     = r_y;
  assign bus.y_vld = r_y_vld;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for the round-robin arbitrated mux (WIDTH=8, MAX_HOLD=4).
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  logic [3:0] exp_sel;
  logic [3:0] prev_sel;
  logic [7:0] dv [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.req = 4'b0000;
    bus.d0 = 8'h00; bus.d1 = 8'h00; bus.d2 = 8'h00; bus.d3 = 8'h00;
    rst_n = 1'b0;
    #3;
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_vld", 32'(bus.y_vld), 32'h0);

    // basic latency, then drop all requests mid-grant
    do_reset();
    bus.req = 4'b0001; bus.d0 = 8'hA5;
    step();
    chk("lat_sel_c1", 32'(bus.sel), 32'h1);
    chk("lat_vld_c1", 32'(bus.y_vld), 32'h0);
    step();
    chk("lat_y_c2", 32'(bus.y), 32'hA5);
    chk("lat_vld_c2", 32'(bus.y_vld), 32'h1);
    bus.req = 4'b0000; bus.d0 = 8'h5A;
    step();
    chk("drop_sel", 32'(bus.sel), 32'h0);
    chk("drop_vld_pend", 32'(bus.y_vld), 32'h1);
    step();
    chk("drop_vld", 32'(bus.y_vld), 32'h0);
    chk("drop_yhold", 32'(bus.y), 32'h5A);
    step();
    chk("idle_sel", 32'(bus.sel), 32'h0);
    chk("idle_yhold", 32'(bus.y), 32'h5A);

    // all four requesting: four-cycle slots rotating 0,1,2,3,0
    do_reset();
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    bus.d0 = dv[0]; bus.d1 = dv[1]; bus.d2 = dv[2]; bus.d3 = dv[3];
    bus.req = 4'b1111;
    prev_sel = 4'b0000;
    for (int c = 1; c <= 17; c++) begin
      step();
      exp_sel = 4'b0001 << (((c - 1) / 4) % 4);
      chk($sformatf("rot_sel_c%0d", c), 32'(bus.sel), 32'(exp_sel));
      if (c >= 2) begin
        chk($sformatf("rot_y_c%0d", c), 32'(bus.y),
            32'(dv[((c - 2) / 4) % 4]));
        chk($sformatf("rot_vld_c%0d", c), 32'(bus.y_vld), 32'h1);
      end
      prev_sel = exp_sel;
    end

    // lone requester keeps the grant with no forced gap
    do_reset();
    bus.req = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("solo_sel_c%0d", c), 32'(bus.sel), 32'h4);
      if (c >= 2) chk($sformatf("solo_vld_c%0d", c), 32'(bus.y_vld), 32'h1);
    end

    // owner drops while another waits: direct hand-over, no idle cycle
    do_reset();
    bus.req = 4'b0001;
    step();
    chk("ho_sel_a", 32'(bus.sel), 32'h1);
    bus.req = 4'b0101;
    step();
    chk("ho_sel_b", 32'(bus.sel), 32'h1);
    bus.req = 4'b0100;
    step();
    chk("ho_sel_c", 32'(bus.sel), 32'h4);
    step();
    chk("ho_vld", 32'(bus.y_vld), 32'h1);
    chk("ho_y", 32'(bus.y), 32'(dv[2]));

    // async reset mid-grant on requester 3, then priority restarts at 0
    do_reset();
    bus.req = 4'b1000;
    step();
    chk("ar_sel_pre", 32'(bus.sel), 32'h8);
    step();
    chk("ar_vld_pre", 32'(bus.y_vld), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sel", 32'(bus.sel), 32'h0);
    chk("ar_y", 32'(bus.y), 32'h0);
    chk("ar_vld", 32'(bus.y_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1001;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("ar_post_c%0d", c), 32'(bus.sel), (c <= 4) ? 32'h1 : 32'h8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
